// File: rtl/fu_result_stage.sv
// Registered result FIFO between the Mosaic functional unit and writeback.
// Optional sticky-flag accumulator enabled by defining FU_STICKY_FLAGS_EN.
module fu_result_stage #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [31:0]                  i_in_z,
  input  logic [3:0]                   i_in_flags,
  input  logic [TAG_W-1:0]             i_in_tag,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  output logic [31:0]                  o_out_z,
  output logic [3:0]                   o_out_flags,
  output logic [TAG_W-1:0]             o_out_tag,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  input  logic                         i_clr_sticky,
  output logic [3:0]                   o_sticky
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = 32 + 4 + TAG_W;

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [ENT_W-1:0] w_head;
  logic             w_push;
  logic             w_pop;

  // Ready/valid depend only on the occupancy register, never on the consumer.
  assign o_in_ready  = (r_count != CNT_W'(DEPTH));
  assign o_out_valid = (r_count != CNT_W'(0));
  assign o_level     = r_count;
  assign w_push      = i_in_valid && o_in_ready;
  assign w_pop       = o_out_valid && i_out_ready;

  // Entry storage; contents are don't-care until pointed at by a valid head.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_in_z, i_in_flags, i_in_tag};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presentation, zeroed while empty so stale entries never leak out.
  always_comb begin
    w_head = r_mem[r_rd_ptr];
    if (o_out_valid) begin
      o_out_z     = w_head[ENT_W-1 -: 32];
      o_out_flags = w_head[TAG_W +: 4];
      o_out_tag   = w_head[TAG_W-1:0];
    end else begin
      o_out_z     = 32'd0;
      o_out_flags = 4'd0;
      o_out_tag   = {TAG_W{1'b0}};
    end
  end

`ifdef FU_STICKY_FLAGS_EN
  logic [3:0] r_sticky;

  // Clear takes priority over the accumulated value, then the popped flags OR in.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sticky <= 4'd0;
    end else if (i_clr_sticky) begin
      r_sticky <= w_pop ? o_out_flags : 4'd0;
    end else if (w_pop) begin
      r_sticky <= r_sticky | o_out_flags;
    end else begin
      r_sticky <= r_sticky;
    end
  end

  assign o_sticky = r_sticky;
`else
  logic w_unused_clr;
  assign w_unused_clr = i_clr_sticky;
  assign o_sticky     = 4'd0;
`endif

endmodule

// File: doc/fu_result_stage.md
# fu_result_stage

Registered result buffer directly downstream of the Mosaic functional unit. It captures each completed result word (Z), its condition flags (FLAGS) and a destination tag into a small FIFO, then presents them to the writeback consumer over a valid/ready handshake. Because of this buffer, the functional unit never has to stall on a slow consumer for up to DEPTH results. An optional sticky-flag accumulator records every flag raised since it was last cleared.

## Interface
- DEPTH, 2: FIFO entries; power of two, at least 2.
- TAG_W, 5: destination-tag width.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous and active-high.
- IN_Z  input  32  result word from the functional unit.
- IN_FLAGS  input  4  flags from the functional unit; bit order is preserved end to end.
- IN_TAG  input  TAG_W  destination register tag.
- IN_VALID  input  1  upstream has a result this cycle.
- IN_READY  output  1  stage can accept a push this cycle.
- OUT_Z  output  32  head-entry result.
- OUT_FLAGS  output  4  head-entry flags.
- OUT_TAG  output  TAG_W  head-entry tag.
- OUT_VALID  output  1  head entry is valid.
- OUT_READY  input  1  consumer accepts the head entry.
- LEVEL  output  $clog2(DEPTH+1)  current occupancy.
- CLR_STICKY  input  1  synchronous clear of STICKY.
- STICKY  output  4  accumulated flags.

## Operation
- Push: IN_VALID && IN_READY. Pop: OUT_VALID && OUT_READY.
- Storage is a circular buffer:
  - The write pointer advances on each push and the read pointer on each pop.
  - Each pointer is log2(DEPTH) bits and wraps from DEPTH-1 to 0.
  - Occupancy is held in a separate count register of width $clog2(DEPTH+1).
- IN_READY = (LEVEL != DEPTH). It is derived only from state and never depends on OUT_READY.
- OUT_VALID = (LEVEL != 0).
- OUT_Z, OUT_FLAGS and OUT_TAG show the head entry while OUT_VALID=1. They are forced to 0 while OUT_VALID=0.
- Simultaneous push and pop:
  - Non-empty and not full: LEVEL is unchanged and both pointers advance.
  - Empty: only the push takes effect, since no pop is possible.
  - Full: only the pop takes effect, since IN_READY=0.
- A push attempted while IN_READY=0 is ignored. The upstream must hold its data until accepted.
- The consumer may deassert OUT_READY at any time. The head entry stays stable until it is popped.
- Entries are never reordered, dropped or duplicated.

## Timing
- Latency: a push at edge N is visible on OUT_* with OUT_VALID=1 after edge N. There is no combinational path from IN_* to OUT_*.
- Throughput: one push and one pop per cycle, sustained.
- IN_READY rises in the cycle after a pop from full.
- Reset (asserted at any time, including mid-transfer):
  - Pointers, LEVEL and STICKY go to 0 and all buffered entries are discarded.
  - Resulting outputs: OUT_VALID=0, OUT_Z=0, OUT_FLAGS=0, OUT_TAG=0, IN_READY=1, LEVEL=0, STICKY=0.
- A push or pop in the same cycle that RST deasserts is honoured at the next edge as normal.

## Configuration
- FU_STICKY_FLAGS_EN defined:
  - On each pop, STICKY <= STICKY | OUT_FLAGS.
  - CLR_STICKY=1 sets STICKY to 0 at the edge.
  - CLR_STICKY together with a pop in the same cycle gives STICKY = popped flags: the clear applies first, then the OR.
- FU_STICKY_FLAGS_EN undefined: STICKY is tied to 4'b0, CLR_STICKY is ignored and no accumulator register is built.

## Test plan
- Reset: assert RST mid-cycle with 1 entry buffered. Required: OUT_VALID=0, OUT_Z=0, LEVEL=0 and IN_READY=1 immediately, before any clock edge.
- Single pass-through, OUT_READY=1: push Z=32'hDEADBEEF, FLAGS=4'b0101, TAG=5'd7. Required: OUT_VALID=1 with those values one cycle later; popped the next edge; LEVEL returns to 0.
- Fill to full, DEPTH=2, OUT_READY=0: push 32'h1 then 32'h2, then hold 32'h3 valid for 3 cycles. Required: IN_READY=0 and LEVEL=2; 32'h3 not accepted. Raise OUT_READY: pop order is 1, 2, 3 and 32'h3 is accepted in the cycle after the first pop.
- Streaming: 16 back-to-back pushes (Z=i) with OUT_READY=1. Required: LEVEL stays ≤1, outputs are 0..15 in order with no bubbles, and the pointers wrap correctly.
- Sticky, macro defined: pop entries with flags 4'b0001 then 4'b1000. Required: STICKY=4'b1001. Pulse CLR_STICKY together with a pop of flags 4'b0010. Required: STICKY=4'b0010.
- Sticky, macro undefined: repeat the previous scenario. Required: STICKY=0 throughout.
